// File: rtl/assert_lab_chk_if.sv
// Handshake bundle observed by the assert_lab_chk protocol monitor.
// The master side drives every signal (the block under test, or a bench);
// the slave side is the passive checker, which only reads.
interface assert_lab_chk_if;
   logic       start;
   logic       ready;
   logic       enable;
   logic       done;
   logic       write;
   logic       ack;
   logic       valid;
   logic [2:0] data_out;
   logic [2:0] data_in;
   logic       d_valid;
   logic       burst_start;
   logic       data_valid;
   logic       burst_end;

   modport master (
      output start, ready, enable, done, write, ack, valid,
             data_out, data_in, d_valid, burst_start, data_valid, burst_end
   );

   modport slave (
      input  start, ready, enable, done, write, ack, valid,
             data_out, data_in, d_valid, burst_start, data_valid, burst_end
   );
endinterface

// File: rtl/assert_lab_chk.sv
// assert_lab_chk: passive, synthesizable protocol checker.
// Samples the handshake bundle on every rising clk edge and evaluates rules R0..R6.
// Violations are reported as a sticky per-rule vector (data), a sticky any-fail
// flag (error), a one-cycle registered pulse (out) and a saturating count of
// violating edges (counter). Several rules failing on one edge count once.
// Optional feature macro: BURST_CHK_EN builds the R6 burst-length checker;
// without it data[6] is tied low and the burst signals are ignored.
module assert_lab_chk #(
   parameter int DONE_TIMEOUT = 16,
   parameter int VALID_QUIET  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   assert_lab_chk_if.slave       bus,
   output logic [7:0]            data,
   output logic                  error,
   output logic                  out,
   output logic [31:0]           counter
);

   localparam int TW = $clog2(DONE_TIMEOUT + 1);
   localparam int QW = $clog2(VALID_QUIET + 1);

   // Previous-edge samples used for rise and change detection
   logic       start_q;
   logic       enable_q;
   logic       write_q;
   logic       valid_q;
   logic [2:0] data_out_q;
   logic [2:0] data_in_q;
   logic       din_chg_q;

   // Per-rule tracking state
   logic [2:0]    r0_pipe;
   logic          r1_pend;
   logic [TW-1:0] r1_cnt;
   logic          r2_open;
   logic [2:0]    r2_cnt;
   logic [QW-1:0] quiet_cnt;

   logic [6:0] fail;
   logic       start_rise;
   logic       enable_rise;
   logic       write_rise;
   logic       din_chg;
   logic       r6_fail;

   assign start_rise  = bus.start  & ~start_q;
   assign enable_rise = bus.enable & ~enable_q;
   assign write_rise  = bus.write  & ~write_q;
   assign din_chg     = (bus.data_in != data_in_q);

`ifdef BURST_CHK_EN
   logic       burst_open;
   logic [2:0] burst_cnt;
   logic [2:0] burst_cnt_next;

   // Beat count including this edge's data_valid; a new burst_start takes
   // precedence over anything else sampled on the same edge.
   always_comb begin
      burst_cnt_next = burst_cnt + {2'b00, bus.data_valid};
      r6_fail        = 1'b0;
      if (burst_open && !bus.burst_start) begin
         if (bus.burst_end)
            r6_fail = (burst_cnt_next != 3'd4);
         else if (bus.data_valid && burst_cnt_next == 3'd5)
            r6_fail = 1'b1;
      end
   end

   // R6 burst tracker: open on burst_start, count beats, close on end or overrun
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         burst_open <= 1'b0;
         burst_cnt  <= 3'd0;
      end else if (bus.burst_start) begin
         burst_open <= 1'b1;
         burst_cnt  <= 3'd0;
      end else if (burst_open) begin
         burst_cnt <= burst_cnt_next;
         if (bus.burst_end || (bus.data_valid && burst_cnt_next == 3'd5))
            burst_open <= 1'b0;
      end
   end
`else
   logic unused_burst;
   assign unused_burst = bus.burst_start ^ bus.data_valid ^ bus.burst_end;
   assign r6_fail      = 1'b0;
`endif

   // Evaluate every rule against the current edge's samples
   always_comb begin
      fail    = '0;
      fail[0] = r0_pipe[2] & ~bus.ready;
      fail[1] = r1_pend & ~bus.done & (r1_cnt == TW'(DONE_TIMEOUT));
      fail[2] = r2_open & ~bus.ack & (r2_cnt == 3'd4);
      fail[3] = (quiet_cnt < QW'(VALID_QUIET)) & bus.valid;
      fail[4] = bus.valid & valid_q & (bus.data_out != data_out_q);
      fail[5] = din_chg_q & ~bus.d_valid;
      fail[6] = r6_fail;
   end

   // History registers for edge/change detection and the R0 check pipeline
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_q    <= 1'b0;
         enable_q   <= 1'b0;
         write_q    <= 1'b0;
         valid_q    <= 1'b0;
         data_out_q <= 3'd0;
         data_in_q  <= 3'd0;
         din_chg_q  <= 1'b0;
         r0_pipe    <= 3'd0;
      end else begin
         start_q    <= bus.start;
         enable_q   <= bus.enable;
         write_q    <= bus.write;
         valid_q    <= bus.valid;
         data_out_q <= bus.data_out;
         data_in_q  <= bus.data_in;
         din_chg_q  <= din_chg;
         r0_pipe    <= {r0_pipe[1:0], start_rise};
      end
   end

   // R1 done timer: one pending timer at a time; cleared by done or by timeout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r1_pend <= 1'b0;
         r1_cnt  <= '0;
      end else if (r1_pend) begin
         if (bus.done || r1_cnt == TW'(DONE_TIMEOUT))
            r1_pend <= 1'b0;
         else
            r1_cnt <= r1_cnt + TW'(1);
      end else if (enable_rise) begin
         r1_pend <= 1'b1;
         r1_cnt  <= TW'(1);
      end
   end

   // R2 ack window: ack counts only 2..4 edges after the write rise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r2_open <= 1'b0;
         r2_cnt  <= 3'd0;
      end else if (r2_open) begin
         if ((bus.ack && r2_cnt >= 3'd2) || r2_cnt == 3'd4)
            r2_open <= 1'b0;
         else
            r2_cnt <= r2_cnt + 3'd1;
      end else if (write_rise) begin
         r2_open <= 1'b1;
         r2_cnt  <= 3'd1;
      end
   end

   // R3 quiet window: counts the first VALID_QUIET edges after reset release
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         quiet_cnt <= '0;
      else if (quiet_cnt < QW'(VALID_QUIET))
         quiet_cnt <= quiet_cnt + QW'(1);
   end

   // Reporting: sticky vector, sticky flag, one-cycle pulse and saturating count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data    <= 8'd0;
         error   <= 1'b0;
         out     <= 1'b0;
         counter <= 32'd0;
      end else begin
         data  <= {1'b0, data[6:0] | fail};
         error <= (|data[6:0]) | (|fail);
         out   <= |fail;
         if ((|fail) && counter != 32'hFFFF_FFFF)
            counter <= counter + 32'd1;
      end
   end

endmodule

// File: tb/tb_assert_lab_chk.sv
// Directed bench for assert_lab_chk: a per-edge vector table followed by
// hand-written sequences for the timer, quiet window, reset abort and bursts.
module tb_assert_lab_chk;

   typedef struct packed {
      bit        st, rdy, en, dn, wr, ak, vl;
      bit [2:0]  dout, din;
      bit        dv, bs, dvl, be;
      bit [7:0]  e_data;
      bit        e_out;
      bit [31:0] e_cnt;
   } vec_t;

   logic        clk;
   logic        rst;
   logic [7:0]  data;
   logic        error;
   logic        out;
   logic [31:0] counter;

   int passed = 0;
   int total  = 0;

   assert_lab_chk_if bus ();

   assert_lab_chk dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .data    (data),
      .error   (error),
      .out     (out),
      .counter (counter)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(bit st, bit rdy, bit wr, bit ak, bit vl,
                               bit [2:0] dout, bit [2:0] din, bit dv,
                               bit [7:0] ed, bit eo, bit [31:0] ec);
      vec_t v;
      v        = '0;
      v.st     = st;
      v.rdy    = rdy;
      v.wr     = wr;
      v.ak     = ak;
      v.vl     = vl;
      v.dout   = dout;
      v.din    = din;
      v.dv     = dv;
      v.e_data = ed;
      v.e_out  = eo;
      v.e_cnt  = ec;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else
         passed++;
   endtask

   task automatic drive(input vec_t v);
      bus.start       = v.st;
      bus.ready       = v.rdy;
      bus.enable      = v.en;
      bus.done        = v.dn;
      bus.write       = v.wr;
      bus.ack         = v.ak;
      bus.valid       = v.vl;
      bus.data_out    = v.dout;
      bus.data_in     = v.din;
      bus.d_valid     = v.dv;
      bus.burst_start = v.bs;
      bus.data_valid  = v.dvl;
      bus.burst_end   = v.be;
   endtask

   // One clock edge: drive, clock, then check all outputs 1 time unit later
   task automatic cyc(input vec_t v, input string tag);
      drive(v);
      @(posedge clk);
      #1;
      chk({tag, "_data"},    {24'd0, data},  {24'd0, v.e_data});
      chk({tag, "_out"},     {31'd0, out},   {31'd0, v.e_out});
      chk({tag, "_counter"}, counter,        v.e_cnt);
      chk({tag, "_error"},   {31'd0, error}, {31'd0, |v.e_data});
      $display("%s: data=%02h out=%0b error=%0b counter=%0d", tag, data, out, error, counter);
   endtask

   // Assert reset asynchronously, verify cleared outputs, release before next edge
   task automatic reset_dut();
      vec_t z;
      z = '0;
      rst = 1'b1;
      drive(z);
      #1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_data",    {24'd0, data},  32'd0);
      chk("rst_out",     {31'd0, out},   32'd0);
      chk("rst_counter", counter,        32'd0);
      chk("rst_error",   {31'd0, error}, 32'd0);
      $display("reset: data=%02h out=%0b counter=%0d", data, out, counter);
      rst = 1'b0;
   endtask

   vec_t tbl [37];
   vec_t v;

   initial begin
      // edge-by-edge table after reset release; row i is edge i+1
      tbl[0]  = mk(1,0,0,0,0,3'd0,3'd0,0, 8'h00,0,0);  // start rise
      tbl[1]  = mk(0,0,0,0,0,3'd0,3'd0,0, 8'h00,0,0);
      tbl[2]  = mk(0,1,0,0,0,3'd0,3'd0,0, 8'h00,0,0);  // ready too early
      tbl[3]  = mk(0,0,0,0,0,3'd0,3'd0,0, 8'h01,1,1);  // R0 fails
      tbl[4]  = mk(0,0,0,0,0,3'd0,3'd0,0, 8'h01,0,1);
      tbl[5]  = mk(1,0,0,0,0,3'd0,3'd0,0, 8'h01,0,1);  // start rise
      tbl[6]  = mk(0,0,0,0,0,3'd0,3'd0,0, 8'h01,0,1);
      tbl[7]  = mk(0,0,0,0,0,3'd0,3'd0,0, 8'h01,0,1);
      tbl[8]  = mk(0,1,0,0,0,3'd0,3'd0,0, 8'h01,0,1);  // ready at +3
      tbl[9]  = mk(0,0,1,0,0,3'd0,3'd0,0, 8'h01,0,1);  // write rise
      tbl[10] = mk(0,0,0,0,0,3'd0,3'd0,0, 8'h01,0,1);
      tbl[11] = mk(0,0,0,0,0,3'd0,3'd0,0, 8'h01,0,1);
      tbl[12] = mk(0,0,0,1,0,3'd0,3'd0,0, 8'h01,0,1);  // ack at +3
      tbl[13] = mk(0,0,0,0,0,3'd0,3'd0,0, 8'h01,0,1);
      tbl[14] = mk(0,0,1,0,0,3'd0,3'd0,0, 8'h01,0,1);  // write rise
      tbl[15] = mk(0,0,0,1,0,3'd0,3'd0,0, 8'h01,0,1);  // ack at +1 only
      tbl[16] = mk(0,0,0,0,0,3'd0,3'd0,0, 8'h01,0,1);
      tbl[17] = mk(0,0,0,0,0,3'd0,3'd0,0, 8'h01,0,1);
      tbl[18] = mk(0,0,0,0,0,3'd0,3'd0,0, 8'h05,1,2);  // R2 fails at +4
      tbl[19] = mk(0,0,0,0,0,3'd0,3'd0,0, 8'h05,0,2);
      tbl[20] = mk(0,0,0,0,1,3'd5,3'd0,0, 8'h05,0,2);  // valid, data_out 101
      tbl[21] = mk(0,0,0,0,1,3'd5,3'd0,0, 8'h05,0,2);
      tbl[22] = mk(0,0,0,0,1,3'd7,3'd0,0, 8'h15,1,3);  // data_out changes
      tbl[23] = mk(0,0,0,0,1,3'd7,3'd0,0, 8'h15,0,3);
      tbl[24] = mk(0,0,0,0,0,3'd0,3'd0,0, 8'h15,0,3);
      tbl[25] = mk(0,0,0,0,0,3'd0,3'd1,0, 8'h15,0,3);  // data_in 0->1
      tbl[26] = mk(0,0,0,0,0,3'd0,3'd1,1, 8'h15,0,3);  // d_valid next edge
      tbl[27] = mk(0,0,0,0,0,3'd0,3'd1,0, 8'h15,0,3);
      tbl[28] = mk(0,0,0,0,0,3'd0,3'd2,0, 8'h15,0,3);  // data_in 1->2
      tbl[29] = mk(0,0,0,0,0,3'd0,3'd2,0, 8'h35,1,4);  // no d_valid
      tbl[30] = mk(0,0,0,0,0,3'd0,3'd2,0, 8'h35,0,4);
      tbl[31] = mk(0,0,1,0,0,3'd0,3'd2,0, 8'h35,0,4);  // write rise
      tbl[32] = mk(1,0,0,0,0,3'd0,3'd2,0, 8'h35,0,4);  // start rise
      tbl[33] = mk(0,0,0,0,0,3'd0,3'd2,0, 8'h35,0,4);
      tbl[34] = mk(0,0,0,0,0,3'd0,3'd2,0, 8'h35,0,4);
      tbl[35] = mk(0,0,0,0,0,3'd0,3'd2,0, 8'h35,1,5);  // R0+R2 same edge: +1
      tbl[36] = mk(0,0,0,0,0,3'd0,3'd2,0, 8'h35,0,5);

      rst = 1'b1;
      reset_dut();
      for (int i = 0; i < 37; i++)
         cyc(tbl[i], $sformatf("tbl%0d", i + 1));

      // R1: done 10 edges after arming passes; then no done -> fail at +16
      reset_dut();
      v = '0;
      v.en = 1'b1;
      for (int e = 1; e <= 10; e++)
         cyc(v, $sformatf("r1a_e%0d", e));
      v.dn = 1'b1;
      cyc(v, "r1a_e11");
      v = '0;
      cyc(v, "r1a_e12");
      v.en = 1'b1;
      cyc(v, "r1b_arm");
      for (int k = 1; k <= 15; k++)
         cyc(v, $sformatf("r1b_p%0d", k));
      v.e_data = 8'h02;
      v.e_out  = 1'b1;
      v.e_cnt  = 32'd1;
      cyc(v, "r1b_p16");
      v.e_out = 1'b0;
      cyc(v, "r1b_p17");

      // R3: valid on edge 4 and 5 after release fails, on edge 6 passes
      for (int k = 4; k <= 6; k++) begin
         reset_dut();
         for (int e = 1; e <= k + 1; e++) begin
            v = '0;
            v.vl = (e == k);
            if (k <= 5 && e >= k) begin
               v.e_data = 8'h08;
               v.e_cnt  = 32'd1;
               v.e_out  = (e == k);
            end
            cyc(v, $sformatf("r3_k%0d_e%0d", k, e));
         end
      end

      // Reset mid-operation aborts open R0/R1/R2 windows silently
      reset_dut();
      v = '0;
      v.st = 1'b1;
      v.en = 1'b1;
      v.wr = 1'b1;
      cyc(v, "abort_arm");
      reset_dut();
      v = '0;
      for (int e = 1; e <= 18; e++)
         cyc(v, $sformatf("abort_e%0d", e));

`ifdef BURST_CHK_EN
      // R6: four beats (two back-to-back, last on burst_end) pass; three fail
      reset_dut();
      v = '0; v.bs = 1'b1;             cyc(v, "b4_start");
      v = '0; v.dvl = 1'b1;            cyc(v, "b4_d1");
      v = '0; v.dvl = 1'b1;            cyc(v, "b4_d2");
      v = '0;                          cyc(v, "b4_gap");
      v = '0; v.dvl = 1'b1;            cyc(v, "b4_d3");
      v = '0; v.dvl = 1'b1; v.be = 1'b1; cyc(v, "b4_end");
      v = '0; v.bs = 1'b1;             cyc(v, "b3_start");
      v = '0; v.dvl = 1'b1;            cyc(v, "b3_d1");
      v = '0;                          cyc(v, "b3_gap");
      v = '0; v.dvl = 1'b1;            cyc(v, "b3_d2");
      v = '0; v.dvl = 1'b1; v.be = 1'b1;
      v.e_data = 8'h40; v.e_out = 1'b1; v.e_cnt = 32'd1;
      cyc(v, "b3_end");
      v.dvl = 1'b0; v.be = 1'b0; v.e_out = 1'b0;
      cyc(v, "b3_idle");
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
